// File: rtl/pc_control.sv
// pc_control: architectural PC, next-PC selection, link register, Z/N status
// register and the one-cycle flush pulse sent to fetch/decode on a redirect.
// Sits directly downstream of the opcode decoder and consumes its class code,
// the beq (aluop2) strobe and statusRegWrite, together with the ALU flags.
module pc_control #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [3:0]      branch_and_jump_identifier,
    input  logic            beq,
    input  logic            statusRegWrite,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic [15:0]     imm16,
    input  logic [25:0]     jtarget,
    input  logic [PC_W-1:0] rs_data,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] link_addr,
    output logic            status_z,
    output logic            status_n,
    output logic            flush
);

    // Decoder class codes that steer the PC.
    localparam logic [3:0] ID_JAL = 4'b0001;  // jump-and-link
    localparam logic [3:0] ID_JR  = 4'b0010;  // jump-register
    localparam logic [3:0] ID_BZ  = 4'b0100;  // branch on registered Z

    // Architectural state and its next-state values.
    logic [PC_W-1:0] pc_q,    pc_d;
    logic [PC_W-1:0] link_q,  link_d;
    logic            z_q,     z_d;
    logic            n_q,     n_d;
    logic            flush_q, flush_d;

    // Next-PC datapath.
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_offset;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] jr_target;
    logic [PC_W-1:0] next_pc;
    logic            taken;
    logic            link_we;

    // The low two bits of rs are discarded by jump-register (word alignment).
    logic            unused_rs_low;
    assign unused_rs_low = ^rs_data[1:0];

    // Sequential fetch address; wraps silently modulo 2^PC_W.
    assign seq_pc = pc_q + PC_W'(4);

    // Word offset: sign-extend first, then scale to bytes.
    assign br_offset   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign br_target   = seq_pc + br_offset;

    // Absolute jump keeps the 256 MB region of the delay-free successor.
    assign jump_target = {seq_pc[PC_W-1:PC_W-4], jtarget, 2'b00};

    // Register jumps are forced word aligned.
    assign jr_target   = {rs_data[PC_W-1:2], 2'b00};

    // Priority-ordered next-PC selection. The Z branch deliberately looks at
    // the registered flag so a flag write in the same cycle cannot affect it.
    always_comb begin
        next_pc = seq_pc;
        taken   = 1'b0;
        link_we = 1'b0;
        if (branch_and_jump_identifier == ID_JAL) begin
            next_pc = jump_target;
            taken   = 1'b1;
            link_we = 1'b1;
        end else if (branch_and_jump_identifier == ID_JR) begin
            next_pc = jr_target;
            taken   = 1'b1;
        end else if (branch_and_jump_identifier == ID_BZ) begin
            if (z_q) begin
                next_pc = br_target;
                taken   = 1'b1;
            end
        end else if (beq) begin
            if (alu_zero) begin
                next_pc = br_target;
                taken   = 1'b1;
            end
        end
    end

    // Next-state: a stall freezes all state and suppresses flush; the decoder
    // re-presents the stalled instruction, so nothing is lost or repeated.
    always_comb begin
        pc_d    = pc_q;
        link_d  = link_q;
        z_d     = z_q;
        n_d     = n_q;
        flush_d = 1'b0;
        if (!stall) begin
            pc_d    = next_pc;
            flush_d = taken;
            if (link_we) begin
                link_d = seq_pc;
            end
            if (statusRegWrite) begin
                z_d = alu_zero;
                n_d = alu_neg;
            end
        end
    end

    // State registers; reset acts immediately and overrides any redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            link_q  <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            link_q  <= link_d;
            z_q     <= z_d;
            n_q     <= n_d;
            flush_q <= flush_d;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = seq_pc;
    assign link_addr = link_q;
    assign status_z  = z_q;
    assign status_n  = n_q;
    assign flush     = flush_q;

endmodule

// File: doc/pc_control.md
Name: pc_control

Overview:
- Program-counter and next-PC stage directly downstream of the opcode decoder.
- Consumes the decoder's branch_and_jump_identifier, beq (aluop2) and statusRegWrite outputs, plus ALU result flags.
- Holds the architectural PC and a two-bit status register (Z, N).
- Issues a one-cycle flush pulse to the fetch/decode pipeline whenever the PC is redirected.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_W, 32, PC and address width (fixed 32 for this core).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze PC, status register and flush generation.
- branch_and_jump_identifier  input  4  decoder class: 0000 R-type, 0001 jump-and-link, 0010 jump-register, 0100 branch-on-status-Z, 1111 other I/J-type.
- beq  input  1  decoder aluop2; conditional equal branch.
- statusRegWrite  input  1  capture ALU flags into status register.
- alu_zero  input  1  ALU result == 0.
- alu_neg  input  1  ALU result bit 31.
- imm16  input  16  sign-extended branch offset (words).
- jtarget  input  26  jump target field.
- rs_data  input  32  register rs value for jump-register.
- pc  output  32  current PC (fetch address).
- pc_plus4  output  32  pc + 4, combinational.
- link_addr  output  32  registered return address for register 31 write.
- status_z  output  1  registered Z flag.
- status_n  output  1  registered N flag.
- flush  output  1  one-cycle redirect pulse.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect) sets the following and holds them while reset is high:
  - pc = RESET_PC
  - link_addr = 0
  - status_z = 0
  - status_n = 0
  - flush = 0
- Next-PC selection, evaluated every cycle; priority is top to bottom:
  - 0001: next = {pc_plus4[31:28], jtarget, 2'b00}; link_addr <= pc_plus4; taken.
  - 0010: next = {rs_data[31:2], 2'b00}; the low two bits are forced to 0; taken.
  - 0100: if status_z then next = pc_plus4 + (sext(imm16) << 2), taken; else next = pc_plus4.
  - beq = 1, for any identifier other than 0001, 0010 or 0100: if alu_zero then next = pc_plus4 + (sext(imm16) << 2), taken; else next = pc_plus4.
  - Otherwise (0000, 1111 without beq, or any undefined code): next = pc_plus4, not taken.
- Arithmetic:
  - All additions are modulo 2^32; wrap-around is silent (pc 32'hFFFF_FFFC with sequential flow goes to 0).
  - The offset is sign-extended to 32 bits before the shift.
- Register updates, on clk rising edge with stall = 0:
  - pc <= next.
  - flush <= taken.
  - If statusRegWrite: status_z <= alu_zero and status_n <= alu_neg.
- Stall = 1:
  - pc, link_addr, status_z and status_n hold.
  - flush <= 0; a redirect is neither lost nor repeated, because the decoder re-presents the same instruction after the stall.
- Branch-on-status hazard: the 0100 decision always uses the registered status_z (the pre-edge value). A statusRegWrite in the same cycle affects only later instructions.
- flush is exactly one cycle per taken redirect. Back-to-back taken redirects on consecutive unstalled cycles give flush high on both cycles.
- link_addr changes only on unstalled 0001 cycles.
- Latency: a redirect is visible on pc one cycle after the instruction is presented, together with flush.

Test Plan:
- Reset release then 3 unstalled cycles of 0000 -> pc = 0, 4, 8, 12; flush stays 0.
- pc = 0x40, 0001, jtarget = 0x0000100 -> next pc = 0x400, link_addr = 0x44, flush pulses 1 cycle.
- pc = 0x80, 1111, beq = 1, alu_zero = 1, imm16 = 0xFFFE -> pc = 0x7C, flush = 1. Repeat with alu_zero = 0 -> pc = 0x84, flush = 0.
- Flag hazard:
  - Cycle 1: statusRegWrite = 1, alu_zero = 1 -> status_z = 1 after the edge.
  - Cycle 1 again with 0100 presented simultaneously while old status_z = 0 -> not taken.
  - Cycle 2: 0100, imm16 = 4 -> branch taken, pc = pc_plus4 + 16.
- 0010 with rs_data = 0x123 while stall = 1 for 2 cycles -> pc holds, flush = 0. Stall drops -> pc = 0x120, flush = 1 for one cycle.
- Assert reset mid-cycle during a taken redirect (pc = 0x200) -> pc = RESET_PC, flush = 0 and status flags = 0 immediately, without waiting for clk.
